// File: rtl/iencode_pkg.sv
// rtl/iencode_pkg.sv - shared op enum, major opcodes and constants for the instruction encoder/loader
package iencode_pkg;

  typedef enum logic [3:0] {
    OP_ADDI = 4'd0,
    OP_ADDS = 4'd1,
    OP_BLT  = 4'd2,
    OP_B    = 4'd3,
    OP_CBZ  = 4'd4,
    OP_LDUR = 4'd5,
    OP_LSL  = 4'd6,
    OP_LSR  = 4'd7,
    OP_MUL  = 4'd8,
    OP_STUR = 4'd9,
    OP_SUBS = 4'd10,
    OP_INV  = 4'd11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FILL = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [5:0]  MAJ_B    = 6'h05;
  localparam logic [7:0]  MAJ_CBZ  = 8'hB4;
  localparam logic [7:0]  MAJ_BLT  = 8'h54;
  localparam logic [9:0]  MAJ_ADDI = 10'h244;
  localparam logic [10:0] MAJ_LSR  = 11'h69A;
  localparam logic [10:0] MAJ_LSL  = 11'h69B;
  localparam logic [10:0] MAJ_SUBS = 11'h758;
  localparam logic [10:0] MAJ_ADDS = 11'h558;
  localparam logic [10:0] MAJ_MUL  = 11'h4D8;
  localparam logic [10:0] MAJ_STUR = 11'h7C0;
  localparam logic [10:0] MAJ_LDUR = 11'h7C2;

  localparam logic [4:0]  BLT_COND  = 5'h0B;
  localparam logic [5:0]  MUL_SHAMT = 6'h1F;
  localparam logic [31:0] NOP_WORD  = 32'h910003FF;

endpackage

// File: rtl/inst_encoder.sv
// rtl/inst_encoder.sv - combinational LEGv8 field-to-word encoder with invalid-opcode flag
module inst_encoder
  import iencode_pkg::*;
(
  input  logic [3:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rn,
  input  logic [4:0]  rm,
  input  logic [11:0] imm12,
  input  logic [25:0] imm26,
  input  logic [18:0] imm19,
  input  logic [8:0]  imm9,
  input  logic [5:0]  shamt,
  output logic [31:0] word,
  output logic        invalid
);

  // Forced fields (shamt for ADDS/SUBS/MUL, rm for shifts) mirror what the decoder matches on.
  always_comb begin
    word    = '0;
    invalid = 1'b0;
    case (opcode)
      OP_B:    word = {MAJ_B, imm26};
      OP_CBZ:  word = {MAJ_CBZ, imm19, rd};
      OP_BLT:  word = {MAJ_BLT, imm19, BLT_COND};
      OP_ADDI: word = {MAJ_ADDI, imm12, rn, rd};
      OP_ADDS: word = {MAJ_ADDS, rm, 6'h00, rn, rd};
      OP_SUBS: word = {MAJ_SUBS, rm, 6'h00, rn, rd};
      OP_MUL:  word = {MAJ_MUL, rm, MUL_SHAMT, rn, rd};
      OP_LSL:  word = {MAJ_LSL, 5'h00, shamt, rn, rd};
      OP_LSR:  word = {MAJ_LSR, 5'h00, shamt, rn, rd};
      OP_STUR: word = {MAJ_STUR, imm9, 2'b00, rn, rd};
      OP_LDUR: word = {MAJ_LDUR, imm9, 2'b00, rn, rd};
      default: invalid = 1'b1;
    endcase
  end

endmodule

// File: rtl/iencode_loader.sv
// rtl/iencode_loader.sv - streams decoded fields, encodes them and writes instruction memory sequentially
// IENC_NOP_PAD_EN: after the last beat, pad the rest of memory with NOP words.
module iencode_loader
  import iencode_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_last,
  input  logic [3:0]    in_opcode,
  input  logic [4:0]    in_rd,
  input  logic [4:0]    in_rn,
  input  logic [4:0]    in_rm,
  input  logic [11:0]   in_imm12,
  input  logic [25:0]   in_imm26,
  input  logic [18:0]   in_imm19,
  input  logic [8:0]    in_imm9,
  input  logic [5:0]    in_shamt,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic [AW:0]   count,
  output logic          done,
  output logic          full,
  output logic          err_opcode
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_C   = (AW+1)'(1);

  state_e        state, state_next;
  logic [AW:0]   count_next;
  logic          we_next, full_next, err_next;
  logic [AW-1:0] addr_next;
  logic [31:0]   wdata_next;
  logic [31:0]   enc_word;
  logic          enc_invalid;
  logic          accept;

  inst_encoder u_enc (
    .opcode  (in_opcode),
    .rd      (in_rd),
    .rn      (in_rn),
    .rm      (in_rm),
    .imm12   (in_imm12),
    .imm26   (in_imm26),
    .imm19   (in_imm19),
    .imm9    (in_imm9),
    .shamt   (in_shamt),
    .word    (enc_word),
    .invalid (enc_invalid)
  );

  assign in_ready = (state == ST_RUN) && (count < DEPTH_C);
  assign accept   = in_valid && in_ready;
  assign done     = (state == ST_DONE);

  always_comb begin
    state_next = state;
    count_next = count;
    we_next    = 1'b0;
    addr_next  = mem_addr;
    wdata_next = mem_wdata;
    full_next  = full;
    err_next   = err_opcode;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_next = ST_RUN;
          count_next = '0;
          full_next  = 1'b0;
          err_next   = 1'b0;
          addr_next  = '0;
        end
      end
      ST_RUN: begin
        if (accept) begin
          if (enc_invalid) begin
            err_next = 1'b1;
          end else begin
            we_next    = 1'b1;
            addr_next  = count[AW-1:0];
            wdata_next = enc_word;
            count_next = count + ONE_C;
          end
          // Filling memory wins over in_last: there is nothing left to pad.
          if (count_next == DEPTH_C) begin
            full_next  = 1'b1;
            state_next = ST_DONE;
          end else if (in_last) begin
`ifdef IENC_NOP_PAD_EN
            state_next = ST_FILL;
`else
            state_next = ST_DONE;
`endif
          end
        end
      end
`ifdef IENC_NOP_PAD_EN
      ST_FILL: begin
        we_next    = 1'b1;
        addr_next  = count[AW-1:0];
        wdata_next = NOP_WORD;
        count_next = count + ONE_C;
        if (count_next == DEPTH_C) begin
          full_next  = 1'b1;
          state_next = ST_DONE;
        end
      end
`endif
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      count      <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      full       <= 1'b0;
      err_opcode <= 1'b0;
    end else begin
      state      <= state_next;
      count      <= count_next;
      mem_we     <= we_next;
      mem_addr   <= addr_next;
      mem_wdata  <= wdata_next;
      full       <= full_next;
      err_opcode <= err_next;
    end
  end

endmodule

// File: doc/iencode_loader.md
Name: iencode_loader

Overview:
- Reverse direction of the instruction decoder: accepts decoded LEGv8 instruction fields over a valid/ready stream, encodes each into a 32-bit instruction word, and writes it sequentially into instruction memory.
- Used by the testbench/boot path to load programs without hand-assembled hex.
- Word encodings match exactly what the decoder recognises, so decode(encode(x)) returns x.

Parameters:
DEPTH, 64, instruction memory depth in words
AW, $clog2(DEPTH), memory address width

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
start  input  1  single-cycle pulse; begins a load at address 0
in_valid  input  1  field beat valid
in_ready  output  1  beat accepted when in_valid & in_ready
in_last  input  1  final beat of program
in_opcode  input  4  op enum (ADDI=0,ADDS=1,BLT=2,B=3,CBZ=4,LDUR=5,LSL=6,LSR=7,MUL=8,STUR=9,SUBS=10,INV=11)
in_rd, in_rn, in_rm  input  5 each  register fields (rd doubles as Rt for CBZ/LDUR/STUR)
in_imm12  input  12  ADDI immediate
in_imm26  input  26  B offset
in_imm19  input  19  CBZ/BLT offset
in_imm9  input  9  LDUR/STUR offset
in_shamt  input  6  LSL/LSR shift amount
mem_we  output  1  memory write strobe
mem_addr  output  AW  write address
mem_wdata  output  32  encoded instruction
count  output  AW+1  words written since start
done  output  1  load finished
full  output  1  sticky: DEPTH words written
err_opcode  output  1  sticky: opcode 11..15 seen

Behaviour:
- Interface: one clock `clk`; `reset` is synchronous and active-high.
- Reset: state IDLE; in_ready, mem_we, mem_addr, mem_wdata, count, done, full and err_opcode all 0. Reset mid-load aborts immediately; no further writes occur.
- States: IDLE, RUN, FILL (feature only), DONE.
  - IDLE -> RUN on start. Clears count, full and err_opcode; write address becomes 0.
  - RUN: in_ready = 1 while count < DEPTH.
  - DONE: done = 1. A start pulse returns to RUN with count, full and errors cleared.
- Accepted valid opcode:
  - Word encoded combinationally and registered.
  - Next cycle: mem_we = 1 for exactly one cycle, mem_addr = count[AW-1:0], mem_wdata = word; count increments.
  - Latency is 1 cycle. Throughput is 1 beat per cycle, back-to-back.
- Invalid opcode (>= 11): beat is consumed, no write, count unchanged, err_opcode set.
- Last beat: in_last accepted moves RUN -> DONE (or -> FILL with the feature) after that beat's write issues. An invalid last beat still ends the load.
- Full: count reaching DEPTH sets full, drops in_ready and moves to DONE. Addresses never wrap.
- start while in RUN is ignored.
- Encodings (unused bits 0):
  - B: [31:26]=6'h05, [25:0]=imm26
  - CBZ: [31:24]=8'hB4, [23:5]=imm19, [4:0]=rd
  - BLT: [31:24]=8'h54, [23:5]=imm19, [4:0]=5'h0B
  - ADDI: [31:22]=10'h244, [21:10]=imm12, [9:5]=rn, [4:0]=rd
  - R-type, with [31:21] = LSR 11'h69A, LSL 11'h69B, SUBS 11'h758, ADDS 11'h558, MUL 11'h4D8:
    - [20:16]=rm, [15:10]=shamt, [9:5]=rn, [4:0]=rd
    - shamt forced 0 for ADDS/SUBS; forced 6'h1F for MUL; rm forced 0 for LSL/LSR.
  - D-type, with [31:21] = STUR 11'h7C0, LDUR 11'h7C2: [20:12]=imm9, [11:10]=0, [9:5]=rn, [4:0]=rd

Optional Feature:
- Macro: IENC_NOP_PAD_EN.
- Defined: after the last beat, state FILL writes NOP 32'h910003FF (ADDI XZR,XZR,#0) once per cycle from count up to DEPTH-1. in_ready = 0 during FILL. Enters DONE with full = 1. A reset during FILL aborts it.
- Undefined: the FILL state does not exist; the remaining memory is untouched.

Decomposition:
- Package iencode_pkg: op enum (same values as the decoder), major-opcode localparams (B, CBZ, BLT, ADDI, R/D-type 11-bit codes), BLT_COND = 5'h0B, MUL_SHAMT = 6'h1F, NOP_WORD.
- One combinational sub-module, inst_encoder (fields -> 32-bit word, plus invalid flag). The FSM, counter and memory port stay in iencode_loader.

Test Plan:
- Start, then beats B imm26=26'h10; ADDI rd=1 rn=2 imm12=5; ADDS rd=3 rn=1 rm=2 (last) -> writes at addresses 0,1,2 of 32'h14000010, 32'h91001441, 32'hAB020023, each one cycle after acceptance; then done=1, count=3.
- LDUR rd=4 rn=5 imm9=8 -> 32'hF84080A4. MUL rd=1 rn=2 rm=3 -> 32'h9B037C41. BLT imm19=2 -> 32'h5400004B. CBZ rd=7 imm19=4 -> 32'hB4000087.
- Opcode 11 between two valid beats -> no write for it; err_opcode=1; addresses stay contiguous (0,1).
- DEPTH=4: stream 5 beats with no last -> 4 writes; full=1, in_ready=0 after the 4th; done=1.
- Reset asserted during back-to-back streaming -> next cycle all outputs 0, no mem_we. A new start writes from address 0.
- With IENC_NOP_PAD_EN, DEPTH=8, 3 beats -> addresses 3..7 receive 32'h910003FF on consecutive cycles; then full=1, done=1.
